// File: rtl/inst_fetch_if.sv
// ROM-side bus of the fetch stage: chip enable and byte address out,
// combinational instruction word back.
interface inst_fetch_if #(
  parameter int INST_ADDR_W = 32,
  parameter int INST_DATA_W = 32
);
  logic                   rom_ce;
  logic [INST_ADDR_W-1:0] rom_addr;
  logic [INST_DATA_W-1:0] rom_inst;

  modport master (
    output rom_ce,
    output rom_addr,
    input  rom_inst
  );

  modport slave (
    input  rom_ce,
    input  rom_addr,
    output rom_inst
  );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage of the five-stage MIPS pipeline: owns the PC, drives the
// instruction ROM, applies stall/branch/flush control and fills IF/ID.
module inst_fetch #(
  parameter int                     INST_ADDR_W = 32,
  parameter int                     INST_DATA_W = 32,
  parameter logic [INST_ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_if_i,
  input  logic                   stall_id_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  inst_fetch_if.master           rom,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_DATA_W-1:0] id_inst_o,
  output logic                   id_adel_o,
  output logic [31:0]            fetch_cnt_o
);

  logic                   ce_q;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [INST_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [INST_ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_DATA_W-1:0] id_inst_q, id_inst_d;
  logic                   id_adel_q, id_adel_d;
  logic [31:0]            fetch_cnt_q, fetch_cnt_d;
  logic                   misaligned;

  assign misaligned   = (pc_q[1:0] != 2'b00);
  assign rom.rom_addr = pc_q;
  assign rom.rom_ce   = ce_q && !misaligned;

  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;
  assign id_adel_o   = id_adel_q;
  assign fetch_cnt_o = fetch_cnt_q;

  // Next PC and pending-branch selection, flush first and sequential fetch last.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (ce_q) begin
      if (flush_i) begin
        pc_d         = new_pc_i;
        pend_valid_d = 1'b0;
      end else if (stall_if_i && branch_flag_i) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = branch_target_i;
      end else if (stall_if_i) begin
        pc_d = pc_q;
      end else if (branch_flag_i) begin
        pc_d         = branch_target_i;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_addr_q;
        pend_valid_d = 1'b0;
      end else if (misaligned) begin
        pc_d = pc_q;
      end else begin
        pc_d = pc_q + INST_ADDR_W'(4);
      end
    end
  end

  // IF/ID contents: bubble on flush, stall-into-running-decode or idle ROM; hold on full stall.
  always_comb begin
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_adel_d   = id_adel_q;
    fetch_cnt_d = fetch_cnt_q;
    if (flush_i || (stall_if_i && !stall_id_i) || (!stall_if_i && !ce_q)) begin
      id_pc_d   = '0;
      id_inst_d = '0;
      id_adel_d = 1'b0;
    end else if (!stall_if_i) begin
      id_pc_d   = pc_q;
      id_inst_d = rom.rom_ce ? rom.rom_inst : '0;
      id_adel_d = misaligned;
      if (!misaligned) begin
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  // Stage state register; reset clears everything including a pending branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q         <= 1'b0;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      id_pc_q      <= '0;
      id_inst_q    <= '0;
      id_adel_q    <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      ce_q         <= 1'b1;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_adel_q    <= id_adel_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for the fetch stage; the ROM returns address >> 2.
module tb_inst_fetch;
  logic        clk;
  logic        rst_n;
  logic        stallIf;
  logic        stallId;
  logic        flush;
  logic [31:0] newPc;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idAdel;
  logic [31:0] fetchCnt;

  int errCount;
  int checkCount;
  logic [31:0] expCnt;

  inst_fetch_if #(.INST_ADDR_W(32), .INST_DATA_W(32)) romBus ();

  assign romBus.rom_inst = romBus.rom_addr >> 2;

  inst_fetch #(.INST_ADDR_W(32), .INST_DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_if_i      (stallIf),
    .stall_id_i      (stallId),
    .flush_i         (flush),
    .new_pc_i        (newPc),
    .branch_flag_i   (branchFlag),
    .branch_target_i (branchTarget),
    .rom             (romBus.master),
    .id_pc_o         (idPc),
    .id_inst_o       (idInst),
    .id_adel_o       (idAdel),
    .fetch_cnt_o     (fetchCnt)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stallIf = 0; stallId = 0; flush = 0; newPc = 0;
    branchFlag = 0; branchTarget = 0;
    #12;
    checkCount++;
    if (romBus.rom_ce !== 1'b0) begin
      errCount++; $display("[TB] FAIL reset_rom_ce: got %b expected 0", romBus.rom_ce);
    end
    checkCount++;
    if ({idPc, idInst, idAdel, fetchCnt} !== 97'd0) begin
      errCount++; $display("[TB] FAIL reset_id: got pc=%h inst=%h adel=%b cnt=%0d expected zeros",
                           idPc, idInst, idAdel, fetchCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checkCount++;
    if (romBus.rom_ce !== 1'b0) begin
      errCount++; $display("[TB] FAIL release_ce_before_edge: got %b expected 0", romBus.rom_ce);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] expInst [5] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3};
    logic [31:0] expAddr [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) expCnt++;
      checkCount++;
      if (romBus.rom_addr !== expAddr[i] || romBus.rom_ce !== 1'b1) begin
        errCount++; $display("[TB] FAIL free_addr[%0d]: got %h ce=%b expected %h ce=1",
                             i, romBus.rom_addr, romBus.rom_ce, expAddr[i]);
      end
      checkCount++;
      if (idInst !== expInst[i] || fetchCnt !== expCnt) begin
        errCount++; $display("[TB] FAIL free_inst[%0d]: got inst=%h cnt=%0d expected inst=%h cnt=%0d",
                             i, idInst, fetchCnt, expInst[i], expCnt);
      end
    end
  endtask

  task automatic test_branch();
    branchFlag = 1'b1; branchTarget = 32'h40;
    tick();
    branchFlag = 1'b0;
    expCnt++;
    checkCount++;
    if (romBus.rom_addr !== 32'h40) begin
      errCount++; $display("[TB] FAIL branch_addr: got %h expected 00000040", romBus.rom_addr);
    end
    checkCount++;
    if (idPc !== 32'h10 || idInst !== 32'h4) begin
      errCount++; $display("[TB] FAIL branch_delay_slot: got pc=%h inst=%h expected pc=10 inst=4", idPc, idInst);
    end
    tick();
    expCnt++;
    checkCount++;
    if (idPc !== 32'h40 || idInst !== 32'h10 || fetchCnt !== expCnt) begin
      errCount++; $display("[TB] FAIL branch_target_id: got pc=%h inst=%h cnt=%0d expected pc=40 inst=10 cnt=%0d",
                           idPc, idInst, fetchCnt, expCnt);
    end
  endtask

  task automatic test_branch_under_stall();
    stallIf = 1'b1; stallId = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branchFlag = (i == 0);
      branchTarget = (i == 0) ? 32'h80 : 32'h0;
      tick();
      checkCount++;
      if (idPc !== 32'h40 || idInst !== 32'h10 || romBus.rom_addr !== 32'h44 || fetchCnt !== expCnt) begin
        errCount++; $display("[TB] FAIL stall_hold[%0d]: got pc=%h inst=%h addr=%h cnt=%0d expected 40/10/44/%0d",
                             i, idPc, idInst, romBus.rom_addr, fetchCnt, expCnt);
      end
    end
    stallIf = 1'b0; stallId = 1'b0; branchFlag = 1'b0;
    tick();
    expCnt++;
    checkCount++;
    if (romBus.rom_addr !== 32'h80 || idPc !== 32'h44 || idInst !== 32'h11) begin
      errCount++; $display("[TB] FAIL stall_pending_redirect: got addr=%h pc=%h inst=%h expected 80/44/11",
                           romBus.rom_addr, idPc, idInst);
    end
    tick();
    expCnt++;
    checkCount++;
    if (romBus.rom_addr !== 32'h84 || idPc !== 32'h80 || fetchCnt !== expCnt) begin
      errCount++; $display("[TB] FAIL stall_pending_clear: got addr=%h pc=%h cnt=%0d expected 84/80/%0d",
                           romBus.rom_addr, idPc, fetchCnt, expCnt);
    end
  endtask

  task automatic test_stall_bubble();
    branchFlag = 1'b1; branchTarget = 32'h20;
    tick();
    branchFlag = 1'b0;
    expCnt++;
    stallIf = 1'b1; stallId = 1'b0;
    tick();
    stallIf = 1'b0;
    checkCount++;
    if (idPc !== 32'h0 || idInst !== 32'h0 || fetchCnt !== expCnt || romBus.rom_addr !== 32'h20) begin
      errCount++; $display("[TB] FAIL bubble: got pc=%h inst=%h cnt=%0d addr=%h expected 0/0/%0d/20",
                           idPc, idInst, fetchCnt, romBus.rom_addr, expCnt);
    end
    tick();
    expCnt++;
    checkCount++;
    if (idPc !== 32'h20 || idInst !== 32'h8 || fetchCnt !== expCnt) begin
      errCount++; $display("[TB] FAIL bubble_release: got pc=%h inst=%h cnt=%0d expected 20/8/%0d",
                           idPc, idInst, fetchCnt, expCnt);
    end
  endtask

  task automatic test_flush_priority();
    flush = 1'b1; newPc = 32'h180; branchFlag = 1'b1; branchTarget = 32'h40; stallIf = 1'b1;
    tick();
    flush = 1'b0; branchFlag = 1'b0; stallIf = 1'b0;
    checkCount++;
    if (romBus.rom_addr !== 32'h180 || idPc !== 32'h0 || idInst !== 32'h0 || fetchCnt !== expCnt) begin
      errCount++; $display("[TB] FAIL flush: got addr=%h pc=%h inst=%h cnt=%0d expected 180/0/0/%0d",
                           romBus.rom_addr, idPc, idInst, fetchCnt, expCnt);
    end
    tick();
    expCnt++;
    checkCount++;
    if (idPc !== 32'h180 || idInst !== 32'h60 || romBus.rom_addr !== 32'h184) begin
      errCount++; $display("[TB] FAIL flush_resume: got pc=%h inst=%h addr=%h expected 180/60/184",
                           idPc, idInst, romBus.rom_addr);
    end
  endtask

  task automatic test_wrap();
    flush = 1'b1; newPc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    tick();
    expCnt++;
    checkCount++;
    if (romBus.rom_addr !== 32'h0 || idPc !== 32'hFFFF_FFFC || idInst !== 32'h3FFF_FFFF) begin
      errCount++; $display("[TB] FAIL wrap: got addr=%h pc=%h inst=%h expected 0/fffffffc/3fffffff",
                           romBus.rom_addr, idPc, idInst);
    end
  endtask

  task automatic test_misaligned_and_reset();
    branchFlag = 1'b1; branchTarget = 32'h42;
    tick();
    branchFlag = 1'b0;
    expCnt++;
    checkCount++;
    if (romBus.rom_addr !== 32'h42 || romBus.rom_ce !== 1'b0) begin
      errCount++; $display("[TB] FAIL misaligned_ce: got addr=%h ce=%b expected 42 ce=0",
                           romBus.rom_addr, romBus.rom_ce);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checkCount++;
      if (idAdel !== 1'b1 || idInst !== 32'h0 || idPc !== 32'h42 || romBus.rom_addr !== 32'h42 ||
          fetchCnt !== expCnt) begin
        errCount++; $display("[TB] FAIL misaligned_hold[%0d]: got adel=%b inst=%h pc=%h addr=%h cnt=%0d expected 1/0/42/42/%0d",
                             i, idAdel, idInst, idPc, romBus.rom_addr, fetchCnt, expCnt);
      end
    end
    flush = 1'b1; newPc = 32'h0;
    tick();
    flush = 1'b0;
    tick();
    tick();
    expCnt += 2;
    checkCount++;
    if (romBus.rom_addr !== 32'h8 || romBus.rom_ce !== 1'b1 || idPc !== 32'h4 || idInst !== 32'h1 ||
        idAdel !== 1'b0 || fetchCnt !== expCnt) begin
      errCount++; $display("[TB] FAIL misaligned_recover: got addr=%h ce=%b pc=%h inst=%h adel=%b cnt=%0d expected 8/1/4/1/0/%0d",
                           romBus.rom_addr, romBus.rom_ce, idPc, idInst, idAdel, fetchCnt, expCnt);
    end
    // Leave a pending branch behind, then reset between clock edges
    stallIf = 1'b1; stallId = 1'b1; branchFlag = 1'b1; branchTarget = 32'h200;
    tick();
    stallIf = 1'b0; stallId = 1'b0; branchFlag = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (romBus.rom_ce !== 1'b0 || romBus.rom_addr !== 32'h0 || idPc !== 32'h0 || idInst !== 32'h0 ||
        idAdel !== 1'b0 || fetchCnt !== 32'h0) begin
      errCount++; $display("[TB] FAIL async_reset: got ce=%b addr=%h pc=%h inst=%h adel=%b cnt=%0d expected zeros",
                           romBus.rom_ce, romBus.rom_addr, idPc, idInst, idAdel, fetchCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checkCount++;
    if (romBus.rom_addr !== 32'h4 || idPc !== 32'h0 || fetchCnt !== 32'd1) begin
      errCount++; $display("[TB] FAIL reset_clears_pending: got addr=%h pc=%h cnt=%0d expected 4/0/1",
                           romBus.rom_addr, idPc, fetchCnt);
    end
  endtask

  initial begin
    errCount = 0;
    checkCount = 0;
    expCnt = 32'd0;
    test_reset();
    test_free_run();
    test_branch();
    test_branch_under_stall();
    test_stall_bubble();
    test_flush_priority();
    test_wrap();
    test_misaligned_and_reset();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
